// File: rtl/rom_fetch_sequencer.sv
// Instruction-ROM program-flow controller: owns the IP, issues fetched words, resolves JMP/BLE/NOP-delay.
// Optional macro NOP_DELAY_EN: NOP count field produces a WAIT of that many cycles (24-bit down-counter).
module rom_fetch_sequencer #(
  parameter logic [3:0] P_OP_NOP = 4'd0,
  parameter logic [3:0] P_OP_BLE = 4'd2,
  parameter logic [3:0] P_OP_JMP = 4'd5
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oIP,
  input  logic [27:0] iInstruction,
  output logic [27:0] oInstruction,
  output logic        oValid,
  input  logic        iBranchTaken,
  input  logic        iStall,
  output logic        oBusy
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_RESOLVE} state_t;

  state_t      state_q, state_d;
  logic [15:0] ip_q, ip_d;
  logic [15:0] tgt_q, tgt_d;
  logic [27:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic [3:0]  opcode;
  logic [15:0] target;
  assign opcode = iInstruction[27:24];
  assign target = {8'h00, iInstruction[23:16]};

`ifdef NOP_DELAY_EN
  logic [23:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    ip_d    = ip_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    valid_d = 1'b0;
`ifdef NOP_DELAY_EN
    cnt_d   = cnt_q;
`endif
    if (!iStall) begin
      case (state_q)
        S_RUN: begin
          instr_d = iInstruction;
          valid_d = 1'b1;
          ip_d    = ip_q + 16'd1;
          if (opcode == P_OP_JMP) begin
            ip_d = target;
          end else if (opcode == P_OP_BLE) begin
            // IP already moves to BLE+1; RESOLVE only redirects when taken
            tgt_d   = target;
            state_d = S_RESOLVE;
          end
`ifdef NOP_DELAY_EN
          else if (opcode == P_OP_NOP && iInstruction[23:0] != 24'd0) begin
            cnt_d   = iInstruction[23:0];
            state_d = S_WAIT;
          end
`endif
        end
`ifdef NOP_DELAY_EN
        S_WAIT: begin
          cnt_d = cnt_q - 24'd1;
          if (cnt_q <= 24'd1) state_d = S_RUN;
        end
`endif
        S_RESOLVE: begin
          if (iBranchTaken) ip_d = tgt_q;
          state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
    busy_d = (state_d != S_RUN);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_RUN;
      ip_q    <= 16'd0;
      tgt_q   <= 16'd0;
      instr_q <= 28'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef NOP_DELAY_EN
      cnt_q   <= 24'd0;
`endif
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef NOP_DELAY_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign oIP          = ip_q;
  assign oInstruction = instr_q;
  assign oValid       = valid_q;
  assign oBusy        = busy_q;

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Scoreboard bench for rom_fetch_sequencer: stimulus pushes (cycle, word) expectations, monitor checks issues.
module tb_rom_fetch_sequencer;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] oIP;
  logic [27:0] iInstruction, oInstruction;
  logic        oValid, oBusy;
  logic        iBranchTaken = 1'b0;
  logic        iStall = 1'b0;

  logic [27:0] rom [0:255];
  logic        big_mode = 1'b0;
  assign iInstruction = big_mode ? {4'h1, 8'h00, oIP} : rom[oIP[7:0]];

  rom_fetch_sequencer dut (
    .Clock(Clock), .Reset(Reset), .oIP(oIP), .iInstruction(iInstruction),
    .oInstruction(oInstruction), .oValid(oValid), .iBranchTaken(iBranchTaken),
    .iStall(iStall), .oBusy(oBusy)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  typedef struct { int c; logic [27:0] w; } exp_t;
  exp_t q[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [27:0] alu(input int a);
    return {4'h1, 8'hA5, a[15:0]};
  endfunction
  function automatic logic [27:0] jmp(input logic [7:0] t);
    return {4'h5, t, 16'h0000};
  endfunction
  function automatic logic [27:0] ble(input logic [7:0] t);
    return {4'h2, t, 16'h0000};
  endfunction
  function automatic logic [27:0] nop(input logic [23:0] n);
    return {4'h0, n};
  endfunction

  // Monitor: every valid issue must match the head of the queue in word and cycle
  always @(negedge Clock) begin
    exp_t e;
    if (oValid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL issue_unexpected: got %h want none (cycle %0d)", oInstruction, cyc);
      end else begin
        e = q.pop_front();
        chk("issue_word", {4'h0, oInstruction}, {4'h0, e.w});
        chk("issue_cycle", cyc, e.c);
      end
    end else if (q.size() != 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      n_chk++;
      $display("FAIL issue_missing: got no issue want %h at cycle %0d", e.w, e.c);
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge Clock);
  endtask

  task automatic push(input int c, input logic [27:0] w);
    exp_t e;
    e.c = c;
    e.w = w;
    q.push_back(e);
  endtask

  task automatic init_rom();
    for (int i = 0; i < 256; i++) rom[i] = alu(i);
  endtask

  task automatic do_reset(output int base);
    Reset  = 1'b1;
    iStall = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    chk("reset_oIP", {16'h0, oIP}, 32'd0);
    chk("reset_oValid", {31'h0, oValid}, 32'd0);
    chk("reset_oBusy", {31'h0, oBusy}, 32'd0);
    chk("reset_oInstr", {4'h0, oInstruction}, 32'd0);
    chk("queue_drained", q.size(), 32'd0);
    Reset = 1'b0;
    base  = cyc + 1;
  endtask

  initial begin
    int b;
    int seq_a[10] = '{0, 1, 2, 3, 4, 5, 2, 3, 4, 5};

    // Sequential code then JMP 2 at address 5
    init_rom();
    rom[5] = jmp(8'd2);
    do_reset(b);
    for (int i = 0; i < 10; i++) push(b + i, rom[seq_a[i]]);
    for (int i = 0; i < 4; i++) begin
      wait_to(b + i);
      chk("seq_oIP", {16'h0, oIP}, i + 1);
    end
    wait_to(b + 5);
    chk("jmp_oIP", {16'h0, oIP}, 32'd2);
    wait_to(b + 9);

    // BLE taken (iBranchTaken held high everywhere; only RESOLVE may use it)
    init_rom();
    rom[0]  = jmp(8'd10);
    rom[11] = ble(8'd10);
    rom[13] = jmp(8'd13);
    iBranchTaken = 1'b1;
    do_reset(b);
    push(b, jmp(8'd10)); push(b + 1, alu(10)); push(b + 2, ble(8'd10));
    push(b + 4, alu(10)); push(b + 5, ble(8'd10)); push(b + 7, alu(10));
    wait_to(b + 2);
    chk("ble_busy_resolve", {31'h0, oBusy}, 32'd1);
    chk("ble_oIP_next", {16'h0, oIP}, 32'd12);
    wait_to(b + 3);
    chk("ble_busy_after", {31'h0, oBusy}, 32'd0);
    chk("ble_taken_oIP", {16'h0, oIP}, 32'd10);
    wait_to(b + 7);

    // BLE not taken
    iBranchTaken = 1'b0;
    do_reset(b);
    push(b, jmp(8'd10)); push(b + 1, alu(10)); push(b + 2, ble(8'd10));
    push(b + 4, alu(12)); push(b + 5, jmp(8'd13)); push(b + 6, jmp(8'd13));
    wait_to(b + 3);
    chk("ble_nt_oIP", {16'h0, oIP}, 32'd12);
    wait_to(b + 6);

    // NOP with count 4 at address 0
    init_rom();
    rom[0] = nop(24'd4);
    do_reset(b);
    push(b, nop(24'd4));
`ifdef NOP_DELAY_EN
    push(b + 5, alu(1)); push(b + 6, alu(2));
    for (int i = 1; i < 4; i++) begin
      wait_to(b + i);
      chk("nop_busy", {31'h0, oBusy}, 32'd1);
    end
    wait_to(b + 5);
    chk("nop_busy_done", {31'h0, oBusy}, 32'd0);
    wait_to(b + 6);
`else
    push(b + 1, alu(1)); push(b + 2, alu(2));
    wait_to(b + 1);
    chk("nop_busy", {31'h0, oBusy}, 32'd0);
    wait_to(b + 2);
`endif

    // Stall 3 cycles in RUN, then 3 cycles inside the NOP wait
    init_rom();
    rom[2] = nop(24'd4);
    rom[5] = jmp(8'd5);
    do_reset(b);
    push(b, alu(0)); push(b + 4, alu(1)); push(b + 5, nop(24'd4));
`ifdef NOP_DELAY_EN
    push(b + 13, alu(3)); push(b + 14, alu(4));
    push(b + 15, jmp(8'd5)); push(b + 16, jmp(8'd5));
`else
    push(b + 6, alu(3)); push(b + 10, alu(4));
    for (int i = 11; i <= 16; i++) push(b + i, jmp(8'd5));
`endif
    wait_to(b);
    iStall = 1'b1;
    wait_to(b + 2);
    chk("stall_run_oIP", {16'h0, oIP}, 32'd1);
    chk("stall_run_instr", {4'h0, oInstruction}, {4'h0, alu(0)});
    wait_to(b + 3);
    iStall = 1'b0;
    wait_to(b + 6);
    iStall = 1'b1;
    wait_to(b + 8);
`ifdef NOP_DELAY_EN
    chk("stall_wait_oIP", {16'h0, oIP}, 32'd3);
    chk("stall_wait_instr", {4'h0, oInstruction}, {4'h0, nop(24'd4)});
    chk("stall_wait_busy", {31'h0, oBusy}, 32'd1);
`else
    chk("stall_wait_oIP", {16'h0, oIP}, 32'd4);
    chk("stall_wait_instr", {4'h0, oInstruction}, {4'h0, alu(3)});
`endif
    wait_to(b + 9);
    iStall = 1'b0;
    wait_to(b + 16);

    // Reset while in RESOLVE with the branch taken
    init_rom();
    rom[0]  = jmp(8'd10);
    rom[11] = ble(8'd10);
    iBranchTaken = 1'b1;
    do_reset(b);
    push(b, jmp(8'd10)); push(b + 1, alu(10)); push(b + 2, ble(8'd10));
    wait_to(b + 2);
    chk("resolve_busy", {31'h0, oBusy}, 32'd1);
    do_reset(b);
    push(b, jmp(8'd10));
    wait_to(b);
    chk("post_reset_oIP", {16'h0, oIP}, 32'd10);

    // Run sequentially through 16'hFFFF and wrap to 0
    big_mode = 1'b1;
    iBranchTaken = 1'b0;
    do_reset(b);
    for (int i = 0; i <= 65536; i++) push(b + i, {4'h1, 8'h00, i[15:0]});
    wait_to(b + 65534);
    chk("wrap_oIP_ffff", {16'h0, oIP}, 32'h0000FFFF);
    wait_to(b + 65535);
    chk("wrap_oIP_zero", {16'h0, oIP}, 32'd0);
    wait_to(b + 65536);
    chk("wrap_oIP_one", {16'h0, oIP}, 32'd1);

    do_reset(b);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rom_fetch_sequencer.md
# rom_fetch_sequencer

Program-flow controller for the instruction ROM. Owns the instruction pointer, drives the ROM address, and registers each 28-bit instruction into the issue register toward the ALU. Resolves JMP, BLE and NOP-delay flow control, and freezes fetch while a multi-cycle unit (e.g. IMUL1_4) is busy. Sits between the ROM and the MiniAlu decode stage.

## Interface
Parameters:
- P_OP_NOP, 4'd0: NOP opcode.
- P_OP_BLE, 4'd2: BLE opcode.
- P_OP_JMP, 4'd5: JMP opcode.

Ports:
- Clock, in, 1: system clock; all state changes on its rising edge.
- Reset, in, 1: synchronous, active-high reset.
- oIP, out, 16: instruction pointer, wired to the ROM `iAddress`.
- iInstruction, in, 28: combinational ROM output for `oIP`.
- oInstruction, out, 28: registered issued instruction.
- oValid, out, 1: `oInstruction` is a new instruction to execute this cycle.
- iBranchTaken, in, 1: ALU BLE comparison result; sampled only in state RESOLVE.
- iStall, in, 1: a multi-cycle unit is busy; freezes the sequencer.
- oBusy, out, 1: high in states WAIT and RESOLVE.

## Operation
- Instruction fields:
  - opcode = [27:24]
  - target = [23:16], zero-extended to 16 bits
  - NOP count = [23:0]
- Reset values: `oIP`=0, `oInstruction`=0, `oValid`=0, `oBusy`=0, state=RUN, wait counter=0.
- State RUN, when `iStall`=0:
  - `oInstruction` <= `iInstruction`; `oValid` <= 1.
  - JMP: `oIP` <= target; stay in RUN.
  - BLE: `oIP` <= `oIP`+1; go to RESOLVE.
  - NOP with count≠0 (`NOP_DELAY_EN` defined): counter <= count; `oIP` <= `oIP`+1; go to WAIT.
  - Any other instruction, or NOP with count=0: `oIP` <= `oIP`+1.
- State WAIT: `oValid`=0 every cycle.
  - Counter decrements each cycle.
  - When counter=1, go to RUN on that edge.
  - `oInstruction` holds its last value.
- State RESOLVE, one cycle, `oValid`=0. The ALU evaluates the BLE issued the previous cycle.
  - `iBranchTaken`=1: `oIP` <= stored BLE target.
  - Otherwise `oIP` is unchanged (already BLE+1).
  - Always returns to RUN.
- Stall: `iStall`=1 in any state freezes state, `oIP`, counter and `oInstruction`.
  - `oValid`=0 for every stalled cycle.
  - The sequencer resumes on the first cycle with `iStall`=0.
- Priority: Reset > `iStall` > state logic.
- `oIP`+1 wraps 16'hFFFF -> 16'h0000.
- A JMP to its own address loops forever, one valid JMP per cycle.
- Reset mid-WAIT or mid-RESOLVE discards the count and the pending branch.

## Timing
- Fetch-to-issue latency: 1 cycle. The ROM is combinational, and `oInstruction` is valid the cycle after `oIP` presents its address.
- Throughput: 1 instruction/cycle for sequential code and JMP (zero bubbles).
- BLE: exactly 1 bubble, regardless of outcome.
- NOP with count N (`NOP_DELAY_EN` defined): NOP issued, then N bubble cycles, then the next instruction. Stall cycles add to this.
- `iBranchTaken` has an effective setup requirement: it must be valid in the RESOLVE cycle only. Its value is ignored in all other states.
- `oBusy` is registered and matches the state decode in the same cycle.

## Configuration
- `NOP_DELAY_EN` defined:
  - The NOP count field creates a WAIT of count cycles.
  - The 24-bit down-counter is instantiated.
- `NOP_DELAY_EN` undefined:
  - NOP is a single-cycle instruction; the count field is ignored.
  - State WAIT and the counter are removed; `oBusy` reflects RESOLVE only.

## Test plan
- Reset, then sequential ROM with no flow control:
  - `oIP` = 0,1,2,3 on consecutive cycles.
  - `oValid`=1 from cycle 1.
  - `oInstruction` equals the ROM word at `oIP`−1.
- JMP target 8'd2 at address 5:
  - After JMP issues, `oIP`=2 the next cycle.
  - No bubble; issued address sequence 4,5,2,3.
- BLE target 8'd10 at address 11, `iBranchTaken`=1 in RESOLVE:
  - One `oValid`=0 cycle, then address 10 issues.
  - Repeat with `iBranchTaken`=0: one bubble, then address 12 issues.
- NOP with count 24'd4 at address 0 (`NOP_DELAY_EN` defined):
  - NOP valid, then exactly 4 cycles `oValid`=0 with `oBusy`=1.
  - Address 1 then issues.
  - Without the macro, address 1 issues the cycle after the NOP.
- `iStall` held 3 cycles during RUN and during WAIT:
  - `oIP`, `oInstruction` and the counter are frozen.
  - `oValid`=0 while stalled.
  - The total NOP delay is extended by exactly 3 cycles.
- Reset asserted in RESOLVE with `iBranchTaken`=1, and `oIP` at 16'hFFFF advancing:
  - Reset yields `oIP`=0, `oValid`=0, state RUN, and the branch is not taken.
  - Wrap from 16'hFFFF to 16'h0000 with no error.
